// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-line memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 256;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on a tie the port that did not win last time is chosen.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic idx
);

  always_comb begin
    valid = req0 | req1;
    idx   = PORT_I;
    if (req0 && req1) begin
      idx = ~last_grant;
    end else if (req1) begin
      idx = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction- and data-cache line requests onto one off-chip memory port.
//   state      | meaning
//   ST_IDLE    | no transaction; pick a requester
//   ST_BUSY    | request presented to memory, waiting for mem_ack_i
//   ST_RELEASE | one-cycle gap so the acked requester can drop its enable
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [DATA_W-1:0] req0_data_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [DATA_W-1:0] req1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              grant_o,
  output logic              timeout_o
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  arb_state_e        state;
  logic              last_grant;
  logic              grant_q;
  logic [7:0]        cnt;
  logic [7:0]        cnt_inc;
  logic              timeout_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              write_q;
  logic              pick_valid;
  logic              pick_idx;
  logic              ack_hit;

  rr_pick2 u_pick (
    .req0       (req0_enable_i),
    .req1       (req1_enable_i),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      last_grant <= PORT_D;
      grant_q    <= PORT_I;
      cnt        <= 8'd0;
      timeout_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state      <= ST_BUSY;
            grant_q    <= pick_idx;
            last_grant <= pick_idx;
            cnt        <= 8'd0;
            addr_q     <= pick_idx ? req1_addr_i  : req0_addr_i;
            data_q     <= pick_idx ? req1_data_i  : req0_data_i;
            write_q    <= pick_idx ? req1_write_i : req0_write_i;
          end
        end
        ST_BUSY: begin
          cnt <= cnt_inc;
          // Sticky: a stuck memory is flagged but the transaction keeps waiting.
          if (cnt_inc == TIMEOUT_CNT) timeout_q <= 1'b1;
          if (mem_ack_i) state <= ST_RELEASE;
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced low whenever reset is asserted, even before the reset edge.
  assign ack_hit      = rst_i && (state == ST_BUSY) && mem_ack_i;
  assign req0_ack_o   = ack_hit && (grant_q == PORT_I);
  assign req1_ack_o   = ack_hit && (grant_q == PORT_D);
  assign req0_data_o  = req0_ack_o ? mem_data_i : '0;
  assign req1_data_o  = req1_ack_o ? mem_data_i : '0;
  assign mem_enable_o = rst_i && (state == ST_BUSY);
  assign mem_write_o  = rst_i && write_q;
  assign mem_addr_o   = rst_i ? addr_q : '0;
  assign mem_data_o   = rst_i ? data_q : '0;
  assign busy_o       = rst_i && (state != ST_IDLE);
  assign grant_o      = rst_i && grant_q;
  assign timeout_o    = rst_i && timeout_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all request and memory addresses.
REQ-002 Parameter DATA_W, default 256, width of one cache line on every data port.
REQ-003 Parameter TIMEOUT, default 255, BUSY-cycle count at which timeout_o sets; 8-bit counter.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-low.
REQ-006 req0_enable_i / req0_write_i  in  1/1  port 0 (instruction cache) request and write flag.
REQ-007 req0_addr_i / req0_data_i  in  ADDR_W/DATA_W  port 0 line address and write data.
REQ-008 req0_ack_o / req0_data_o  out  1/DATA_W  port 0 completion pulse and read data.
REQ-009 req1_enable_i, req1_write_i, req1_addr_i, req1_data_i, req1_ack_o, req1_data_o: same as port 0, for port 1 (data cache).
REQ-010 mem_enable_o / mem_write_o  out  1/1  off-chip memory request and write flag.
REQ-011 mem_addr_o / mem_data_o  out  ADDR_W/DATA_W  off-chip address and write line.
REQ-012 mem_data_i / mem_ack_i  in  DATA_W/1  off-chip read line and completion pulse.
REQ-013 busy_o / grant_o / timeout_o  out  1/1/1  transaction in flight; granted port index; sticky timeout flag.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, BUSY, RELEASE.
REQ-015 IDLE, no enable high -> stay IDLE; mem_enable_o=0.
REQ-016 IDLE, one enable high -> BUSY next cycle with that port granted.
REQ-017 IDLE, both enables high -> grant the port not equal to last_grant (round-robin); last_grant updates on every grant.
REQ-018 On grant, addr, data and write of the granted port SHALL be registered; mem_addr_o, mem_data_o and mem_write_o SHALL hold them constant through BUSY.
REQ-019 mem_enable_o SHALL be 1 for every BUSY cycle and 0 in IDLE and RELEASE; request-to-mem_enable_o latency exactly 1 cycle.
REQ-020 BUSY with mem_ack_i=1 -> same cycle: granted port ack_o=1 and data_o=mem_data_i; next state RELEASE.
REQ-021 Non-granted port ack_o=0 and data_o=0 at all times; both data_o=0 outside an ack cycle.
REQ-022 RELEASE lasts exactly one cycle and issues no grant; then IDLE. The acked requester must drop enable within this cycle.
REQ-023 mem_ack_i SHALL be ignored in IDLE and RELEASE.
REQ-024 Deassertion of a granted enable during BUSY SHALL NOT abort; ack is still delivered.
REQ-025 BUSY counter clears on grant and increments each BUSY cycle, saturating at 255; when it reaches TIMEOUT, timeout_o sets and holds until reset; the transaction keeps waiting.
REQ-026 busy_o=1 in BUSY and RELEASE; grant_o holds last granted index.

Reset
REQ-027 rst_i=0 at a clock edge -> IDLE, last_grant=1 (port 0 wins first tie), counter=0, timeout_o=0, registered addr/data/write=0.
REQ-028 While in reset, all outputs SHALL be 0, including mid-BUSY; the abandoned transaction's late ack is ignored (REQ-023).

Structure
REQ-029 Shared package mem_arb_pkg: state enum, port index constants (PORT_I=0, PORT_D=1), ADDR_W/DATA_W defaults.
REQ-030 One sub-module rr_pick2: 2-way round-robin selector (two requests, last_grant in; grant valid and index out), purely combinational.

Verification
REQ-031 Port 1 read of 0x0000_0400 alone, mem acks after 10 cycles with line 0xA5..A5 -> mem_enable_o high exactly cycles 1-10, req1_ack_o pulse with data 0xA5..A5, req0_ack_o=0.
REQ-032 Both ports request in the same cycle after reset -> port 0 served first, port 1 issued 2 cycles after port 0 ack (RELEASE + IDLE).
REQ-033 Both ports hold requests continuously for 6 transactions -> grant_o alternates 0,1,0,1,0,1.
REQ-034 Port 1 write 0x0000_0800, port 1 changes req1_addr_i/data during BUSY -> mem_addr_o stays 0x0000_0800 and mem_data_o stays at the grant-time line until ack.
REQ-035 Memory never acks -> timeout_o rises after 255 BUSY cycles and stays 1; mem_enable_o stays 1.
REQ-036 rst_i=0 for one cycle mid-BUSY, then ack arrives -> FSM IDLE, all outputs 0, no ack_o generated.
